// File: rtl/btn_debounce.sv
// Per-channel push-button debouncer: 2-flop synchronizer feeding a 4-state
// stability FSM with registered level and one-cycle press-strobe outputs.
module btn_debounce #(
   parameter int N_BTN           = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_btn_level,
   output logic [N_BTN-1:0] o_btn_pulse
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARM_HIGH = 2'd1,
      HIGH     = 2'd2,
      ARM_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [N_BTN-1:0]     sync_meta;
   logic [N_BTN-1:0]     sync_s;
   state_t               state_q [N_BTN];
   state_t               state_d [N_BTN];
   logic [CNT_WIDTH-1:0] cnt_q   [N_BTN];
   logic [CNT_WIDTH-1:0] cnt_d   [N_BTN];
   logic [N_BTN-1:0]     pulse_d;
   logic [N_BTN-1:0]     level_d;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_meta <= '0;
         sync_s    <= '0;
      end else begin
         sync_meta <= i_btn;
         sync_s    <= sync_meta;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = '0;
      level_d = '0;
      for (int unsigned k = 0; k < N_BTN; k++) begin
         case (state_q[k])
            IDLE: begin
               if (sync_s[k]) begin
                  state_d[k] = ARM_HIGH;
                  cnt_d[k]   = CNT_ONE;
               end
            end
            ARM_HIGH: begin
               if (!sync_s[k]) begin
                  state_d[k] = IDLE;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = HIGH;
                  cnt_d[k]   = '0;
                  pulse_d[k] = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_ONE;
               end
            end
            HIGH: begin
               if (!sync_s[k]) begin
                  state_d[k] = ARM_LOW;
                  cnt_d[k]   = CNT_ONE;
               end
            end
            ARM_LOW: begin
               if (sync_s[k]) begin
                  state_d[k] = HIGH;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = IDLE;
                  cnt_d[k]   = '0;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_ONE;
               end
            end
            default: begin
               state_d[k] = IDLE;
               cnt_d[k]   = '0;
            end
         endcase
         // Outputs are registered from the next state so they change on the
         // same edge as the accepting transition.
         level_d[k] = (state_d[k] == HIGH) || (state_d[k] == ARM_LOW);
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int unsigned k = 0; k < N_BTN; k++) begin
            state_q[k] <= IDLE;
            cnt_q[k]   <= '0;
         end
         o_btn_level <= '0;
         o_btn_pulse <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         o_btn_level <= level_d;
         o_btn_pulse <= pulse_d;
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with N_BTN=3, DEBOUNCE_CYCLES=4.
module tb_btn_debounce;

   localparam int N   = 3;
   localparam int DEB = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] btn;
   logic [N-1:0] level;
   logic [N-1:0] pulse;

   int checks = 0;
   int errors = 0;

   btn_debounce #(
      .N_BTN          (N),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .i_clock    (clk),
      .i_reset_n  (rst_n),
      .i_btn      (btn),
      .o_btn_level(level),
      .o_btn_pulse(pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      btn = 3'b111;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (level !== 3'b000 || pulse !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d level=%b pulse=%b expected 000/000", i, level, pulse);
         end
      end
      btn = 3'b000;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (level !== 3'b000 || pulse !== 3'b000) begin
         errors++;
         $display("FAIL reset_idle level=%b pulse=%b expected 000/000", level, pulse);
      end
   endtask

   // Press on channel 0 held 20 cycles: exactly one pulse after edge 5.
   task automatic test_clean_press();
      logic [N-1:0] exp_l, exp_p;
      btn = 3'b001;
      for (int e = 0; e < 20; e++) begin
         tick();
         exp_l = (e >= 5) ? 3'b001 : 3'b000;
         exp_p = (e == 5) ? 3'b001 : 3'b000;
         checks++;
         if (level !== exp_l || pulse !== exp_p) begin
            errors++;
            $display("FAIL clean_press edge=%0d level=%b pulse=%b expected %b/%b", e, level, pulse, exp_l, exp_p);
         end
      end
   endtask

   task automatic test_release();
      logic [N-1:0] exp_l, exp_p;
      btn = 3'b000;
      for (int e = 0; e < 10; e++) begin
         tick();
         exp_l = (e < 5) ? 3'b001 : 3'b000;
         checks++;
         if (level !== exp_l || pulse !== 3'b000) begin
            errors++;
            $display("FAIL release edge=%0d level=%b pulse=%b expected %b/000", e, level, pulse, exp_l);
         end
      end
      btn = 3'b001;
      for (int e = 0; e < 10; e++) begin
         tick();
         exp_l = (e >= 5) ? 3'b001 : 3'b000;
         exp_p = (e == 5) ? 3'b001 : 3'b000;
         checks++;
         if (level !== exp_l || pulse !== exp_p) begin
            errors++;
            $display("FAIL second_press edge=%0d level=%b pulse=%b expected %b/%b", e, level, pulse, exp_l, exp_p);
         end
      end
      btn = 3'b000;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (level !== 3'b000) begin
         errors++;
         $display("FAIL release_settle level=%b expected 000", level);
      end
   endtask

   task automatic test_bounce();
      logic [N-1:0] exp_l, exp_p;
      for (int ph = 0; ph < 4; ph++) begin
         btn = (ph % 2 == 0) ? 3'b010 : 3'b000;
         for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (level !== 3'b000 || pulse !== 3'b000) begin
               errors++;
               $display("FAIL bounce ph=%0d level=%b pulse=%b expected 000/000", ph, level, pulse);
            end
         end
      end
      btn = 3'b010;
      for (int e = 0; e < 12; e++) begin
         tick();
         exp_l = (e >= 5) ? 3'b010 : 3'b000;
         exp_p = (e == 5) ? 3'b010 : 3'b000;
         checks++;
         if (level !== exp_l || pulse !== exp_p) begin
            errors++;
            $display("FAIL bounce_settle edge=%0d level=%b pulse=%b expected %b/%b", e, level, pulse, exp_l, exp_p);
         end
      end
      btn = 3'b000;
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] exp_l, exp_p;
      btn = 3'b111;
      for (int e = 0; e < 12; e++) begin
         tick();
         exp_l = (e >= 5) ? 3'b111 : 3'b000;
         exp_p = (e == 5) ? 3'b111 : 3'b000;
         checks++;
         if (level !== exp_l || pulse !== exp_p) begin
            errors++;
            $display("FAIL simultaneous edge=%0d level=%b pulse=%b expected %b/%b", e, level, pulse, exp_l, exp_p);
         end
      end
      btn = 3'b000;
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] exp_l, exp_p;
      btn = 3'b100;
      for (int i = 0; i < 4; i++) tick();   // counter now 2
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (level !== 3'b000 || pulse !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_hold cyc=%0d level=%b pulse=%b expected 000/000", i, level, pulse);
         end
      end
      rst_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         exp_l = (e >= 5) ? 3'b100 : 3'b000;
         exp_p = (e == 5) ? 3'b100 : 3'b000;
         checks++;
         if (level !== exp_l || pulse !== exp_p) begin
            errors++;
            $display("FAIL reset_mid_after edge=%0d level=%b pulse=%b expected %b/%b", e, level, pulse, exp_l, exp_p);
         end
      end
      // Asynchronous clear while HIGH, observed before any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (level !== 3'b000 || pulse !== 3'b000) begin
         errors++;
         $display("FAIL reset_async level=%b pulse=%b expected 000/000", level, pulse);
      end
      btn = 3'b000;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_glitch();
      btn = 3'b001;
      for (int i = 0; i < 3; i++) tick();
      btn = 3'b000;
      for (int e = 0; e < 12; e++) begin
         tick();
         checks++;
         if (level !== 3'b000 || pulse !== 3'b000) begin
            errors++;
            $display("FAIL glitch edge=%0d level=%b pulse=%b expected 000/000", e, level, pulse);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      btn   = 3'b000;
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_glitch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 3, number of independent button channels (index 0 = A, 1 = B, 2 = op).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required to accept a level change; legal range >= 2.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(DEBOUNCE_CYCLES), width of each channel counter.
REQ-004 SHALL have port i_clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port i_btn, input, N_BTN, raw asynchronous push-button levels (1 = pressed).
REQ-007 SHALL have port o_btn_level, output, N_BTN, debounced button level per channel.
REQ-008 SHALL have port o_btn_pulse, output, N_BTN, one-cycle press strobe per channel; drives the operand/opcode latch-enable inputs of the decoder stage.

Function
REQ-009 Each channel SHALL pass i_btn[k] through a 2-flop synchronizer; the second flop output is the sample s[k]; no other logic SHALL use i_btn directly.
REQ-010 Each channel SHALL run an independent 4-state FSM: IDLE (level 0, counter 0), ARM_HIGH (level 0, counting), HIGH (level 1, counter 0), ARM_LOW (level 1, counting).
REQ-011 IDLE -> ARM_HIGH when s=1, counter loaded with 1; IDLE holds otherwise.
REQ-012 ARM_HIGH: s=1 and counter < DEBOUNCE_CYCLES-1 -> counter+1, stay; s=1 and counter = DEBOUNCE_CYCLES-1 -> HIGH; s=0 -> IDLE with counter cleared (glitch rejected).
REQ-013 HIGH -> ARM_LOW when s=0, counter loaded with 1; HIGH holds otherwise.
REQ-014 ARM_LOW: s=0 and counter < DEBOUNCE_CYCLES-1 -> counter+1, stay; s=0 and counter = DEBOUNCE_CYCLES-1 -> IDLE; s=1 -> HIGH with counter cleared.
REQ-015 o_btn_level[k] SHALL be registered: 1 in HIGH and ARM_LOW, 0 in IDLE and ARM_HIGH.
REQ-016 o_btn_pulse[k] SHALL be registered and be 1 for exactly the one cycle following the ARM_HIGH -> HIGH transition; 0 at all other times, including on release.
REQ-017 Latency: raw rising edge sampled at clock edge 0 -> o_btn_level and o_btn_pulse rise after edge 1+DEBOUNCE_CYCLES; pulse falls after edge 2+DEBOUNCE_CYCLES.
REQ-018 A button held indefinitely SHALL produce exactly one pulse; a new pulse requires a full debounced release (return to IDLE) then a new debounced press.
REQ-019 Channels SHALL be fully independent; simultaneous presses on several channels SHALL produce simultaneous pulses (priority resolution belongs to the consumer).
REQ-020 Counters SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-021 Any bounce shorter than DEBOUNCE_CYCLES sample cycles SHALL produce no change on either output.

Reset
REQ-022 While i_reset_n=0, all synchronizer flops, counters and outputs SHALL be 0 and every FSM SHALL be IDLE, independent of i_clock.
REQ-023 Reset asserted mid-count or while HIGH SHALL abort without emitting a pulse; after release, a button still held SHALL be debounced from IDLE and emit one pulse DEBOUNCE_CYCLES+2 edges later.
REQ-024 Reset deassertion SHALL be synchronized to i_clock by the integrating top level; this block requires no internal reset synchronizer.

Verification (N_BTN=3, DEBOUNCE_CYCLES=4)
REQ-025 Clean press: i_btn=3'b001 held 20 cycles -> o_btn_pulse=3'b001 for exactly one cycle after edge 5, o_btn_level[0]=1 from edge 5 onward; no other bits change.
REQ-026 Bounce: i_btn[1] toggles 1,0,1,0 every 2 cycles then held 1 -> no pulse during bounce; single pulse 5 edges after final stable high.
REQ-027 Release: after REQ-025 state, i_btn=0 held -> o_btn_level[0] falls after 5 edges, o_btn_pulse stays 0; second press yields a second pulse.
REQ-028 Simultaneous: i_btn 3'b000 -> 3'b111 -> o_btn_pulse=3'b111 for one cycle, same cycle on all channels.
REQ-029 Reset mid-operation: i_btn[2]=1, assert i_reset_n=0 at counter=2 for 3 cycles -> outputs 0 immediately, no pulse during reset; pulse 6 edges after deassertion with i_btn[2] still 1.
REQ-030 Short glitch: i_btn[0]=1 for 3 cycles then 0 -> o_btn_level and o_btn_pulse remain 0 throughout.
